mem_lsu: RTL and testbench

MEM-stage load/store unit of the pipelined RV32I core. It accepts one load or store per instruction and drives the data-memory request/response handshake (read/write held until resp). It stalls the pipeline while the access is outstanding. For loads it returns sign- or zero-extended writeback data, tagged with the matching regfilemux select (lw/lb/lbu/lh/lhu).

---
 rtl/mem_lsu_pkg.sv | 72 +++++++
 rtl/mem_lsu_load_align.sv | 45 ++++
 rtl/mem_lsu.sv | 138 +++++++++++++
 tb/tb_mem_lsu.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: the core's regfilemux select
// encoding and the LSU state, funct3 and access-size definitions.
package regfilemux;
  typedef enum logic [3:0] {
    alu_out  = 4'b0000,
    br_en    = 4'b0001,
    u_imm    = 4'b0010,
    lw       = 4'b0011,
    pc_plus4 = 4'b0100,
    lb       = 4'b0101,
    lbu      = 4'b0110,
    lh       = 4'b0111,
    lhu      = 4'b1000
  } regfilemux_sel_t;
endpackage

package lsu_types;
  typedef enum logic {IDLE, BUSY} lsu_state_t;

  localparam logic [2:0] lb  = 3'b000;
  localparam logic [2:0] lh  = 3'b001;
  localparam logic [2:0] lw  = 3'b010;
  localparam logic [2:0] lbu = 3'b100;
  localparam logic [2:0] lhu = 3'b101;
  localparam logic [2:0] sb  = 3'b000;
  localparam logic [2:0] sh  = 3'b001;
  localparam logic [2:0] sw  = 3'b010;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} access_size_t;

  // Any funct3 that is not a defined byte/half form falls back to a word access.
  function automatic access_size_t access_size(input logic store, input logic [2:0] funct3);
    if (store) begin
      case (funct3)
        sb:      return SZ_BYTE;
        sh:      return SZ_HALF;
        sw:      return SZ_WORD;
        default: return SZ_WORD;
      endcase
    end
    case (funct3)
      lb, lbu: return SZ_BYTE;
      lh, lhu: return SZ_HALF;
      lw:      return SZ_WORD;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input access_size_t size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input access_size_t size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input access_size_t size, input logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mem_lsu_load_align.sv
// Load formatter: picks the addressed byte/half out of the memory word,
// sign- or zero-extends it and reports the matching regfilemux select.
module lsu_load_align
  import lsu_types::*;
(
  input  logic [31:0]                rdata,
  input  logic [2:0]                 funct3,
  input  logic [1:0]                 off,
  output logic [31:0]                data,
  output regfilemux::regfilemux_sel_t sel
);
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{off, 3'b000} +: 8];
  assign half_lane = rdata[{off[1], 4'b0000} +: 16];

  // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    data = rdata;
    sel  = regfilemux::lw;
    case (funct3)
      lb: begin
        data = {{24{byte_lane[7]}}, byte_lane};
        sel  = regfilemux::lb;
      end
      lbu: begin
        data = {24'h0, byte_lane};
        sel  = regfilemux::lbu;
      end
      lh: begin
        data = {{16{half_lane[15]}}, half_lane};
        sel  = regfilemux::lh;
      end
      lhu: begin
        data = {16'h0, half_lane};
        sel  = regfilemux::lhu;
      end
      default: begin
        data = rdata;
        sel  = regfilemux::lw;
      end
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory access, pipeline stall
// while it is in flight. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_lsu
  import lsu_types::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic                        req_store,
  input  logic [2:0]                  req_funct3,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [31:0]                 req_wdata,
  input  logic [4:0]                  req_rd,
  output logic                        stall,
  output logic                        dmem_read,
  output logic                        dmem_write,
  output logic [ADDR_W-1:0]           dmem_address,
  output logic [31:0]                 dmem_wdata,
  output logic [3:0]                  dmem_byte_enable,
  input  logic [31:0]                 dmem_rdata,
  input  logic                        dmem_resp,
  output logic                        wb_valid,
  output logic [31:0]                 wb_data,
  output logic [4:0]                  wb_rd,
  output regfilemux::regfilemux_sel_t wb_sel,
  output logic                        misalign
);
  lsu_state_t   state;
  lsu_state_t   state_next;
  access_size_t req_size;
  logic         req_misaligned;
  logic         accept;
  logic         complete;

  logic         op_store;
  logic [2:0]   op_funct3;
  logic [4:0]   op_rd;
  logic [1:0]   op_off;

  logic [31:0]                 load_data;
  regfilemux::regfilemux_sel_t load_sel;

  assign req_size = access_size(req_store, req_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign <= 1'b0;
    else      misalign <= (state == IDLE) && req_valid && req_misaligned;
  end
`else
  assign req_misaligned = 1'b0;
  assign misalign       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // A trapped request is consumed in IDLE without ever issuing a memory access.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !req_misaligned) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drops in the resp cycle so the pipeline advances exactly once per access.
  assign stall = ((state == IDLE) && req_valid) || ((state == BUSY) && !dmem_resp);

  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .funct3 (op_funct3),
    .off    (op_off),
    .data   (load_data),
    .sel    (load_sel)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_store         <= 1'b0;
      op_funct3        <= 3'b000;
      op_rd            <= 5'd0;
      op_off           <= 2'b00;
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_address     <= '0;
      dmem_wdata       <= 32'h0;
      dmem_byte_enable <= 4'b0000;
      wb_valid         <= 1'b0;
      wb_data          <= 32'h0;
      wb_rd            <= 5'd0;
      wb_sel           <= regfilemux::alu_out;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        op_store         <= req_store;
        op_funct3        <= req_funct3;
        op_rd            <= req_rd;
        op_off           <= req_addr[1:0];
        dmem_address     <= {req_addr[ADDR_W-1:2], 2'b00};
        dmem_byte_enable <= req_store ? store_be(req_size, req_addr[1:0]) : 4'b1111;
        if (req_store) dmem_wdata <= store_data(req_size, req_wdata);
        dmem_read        <= !req_store;
        dmem_write       <= req_store;
      end
      if (complete) begin
        dmem_read  <= 1'b0;
        dmem_write <= 1'b0;
        if (!op_store) begin
          wb_valid <= 1'b1;
          wb_data  <= load_data;
          wb_rd    <= op_rd;
          wb_sel   <= load_sel;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand-written reset and
// back-to-back sequences, then randomized accesses against a behavioural model.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [3:0]  wb_sel;
  logic        misalign;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [logic [29:0]];

  typedef struct {
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
    logic [3:0]  e_sel;
  } vec_t;

  vec_t vecs [14];

  mem_lsu #(.ADDR_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_store        (req_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_rd           (req_rd),
    .stall            (stall),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .wb_valid         (wb_valid),
    .wb_data          (wb_data),
    .wb_rd            (wb_rd),
    .wb_sel           (wb_sel),
    .misalign         (misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access width in bytes from the instruction encoding.
  function automatic int size_of(input bit st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit model_misaligned(input bit st, input logic [2:0] f3, input logic [31:0] addr);
    int sz  = size_of(st, f3);
    int off = int'(addr[1:0]);
    return (sz == 2 && off % 2 != 0) || (sz == 4 && off != 0);
  endfunction

  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       output logic [3:0] e_be, output logic [31:0] e_wdata,
                       output logic [31:0] e_wb, output logic [3:0] e_sel);
    int sz   = size_of(st, f3);
    int lane = int'(addr[1:0]) / sz * sz;
    logic [31:0] mask;
    logic [31:0] raw;
    e_be = st ? 4'(((1 << sz) - 1) << lane) : 4'b1111;
    for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    raw  = (rdata >> (8 * lane)) & mask;
    if (sz < 4 && !f3[2] && raw[8*sz-1]) raw = raw | ~mask;
    e_wb  = raw;
    e_sel = (sz == 4) ? 4'd3 : (sz == 1) ? (f3[2] ? 4'd6 : 4'd5) : (f3[2] ? 4'd8 : 4'd7);
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input int lat,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic [31:0] e_wb,
                           input logic [3:0] e_sel);
    int stalls = 0;
    logic [29:0] w = addr[31:2];
    if (!mem.exists(w)) mem[w] = $urandom;
    req_valid = 1'b1; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    #1;
    check("accept_stall", 32'(stall), 32'd1);
    check("accept_no_req", 32'({dmem_read, dmem_write}), 32'd0);
    if (stall) stalls++;
`ifdef LSU_MISALIGN_TRAP_EN
    if (model_misaligned(st, f3, addr)) begin
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0; #1;
      check("trap_pulse", 32'(misalign), 32'd1);
      check("trap_no_req", 32'({dmem_read, dmem_write}), 32'd0);
      check("trap_stall", 32'(stall), 32'd0);
      @(posedge clk); @(negedge clk);
      check("trap_pulse_end", 32'(misalign), 32'd0);
      return;
    end
`endif
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); @(negedge clk);
      check("req_read", 32'(dmem_read), 32'(!st));
      check("req_write", 32'(dmem_write), 32'(st));
      check("req_addr", dmem_address, e_addr);
      check("req_be", 32'(dmem_byte_enable), 32'(e_be));
      if (st) check("req_wdata", dmem_wdata, e_wdata);
      check("busy_no_wb", 32'(wb_valid), 32'd0);
      if (k < lat) begin
        check("busy_stall", 32'(stall), 32'd1);
      end else begin
        dmem_rdata = st ? $urandom : mem[w];
        dmem_resp  = 1'b1;
        #1;
        check("resp_stall", 32'(stall), 32'd0);
      end
      if (stall) stalls++;
    end
    check("stall_cycles", 32'(stalls), 32'(lat + 1));
    if (st) mem[w] = (mem[w] & ~byte_mask(e_be)) | (e_wdata & byte_mask(e_be));
    @(posedge clk); @(negedge clk);
    dmem_resp = 1'b0; req_valid = 1'b0;
    #1;
    check("done_no_req", 32'({dmem_read, dmem_write}), 32'd0);
    check("wb_valid", 32'(wb_valid), 32'(!st));
    check("done_stall", 32'(stall), 32'd0);
    check("misalign_low", 32'(misalign), 32'd0);
    if (!st) begin
      check("wb_data", wb_data, e_wb);
      check("wb_rd", 32'(wb_rd), 32'(rd));
      check("wb_sel", 32'(wb_sel), 32'(e_sel));
    end
  endtask

  initial begin
    logic [3:0]  m_be, m_sel;
    logic [31:0] m_wdata, m_wb, r_addr;
    bit          r_st;
    logic [2:0]  r_f3;

    //           st    f3      addr          wdata         rd     rdata         lat e_addr        be       e_wdata       e_wb          sel
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        5'd1,  32'hDEAD_BEEF, 3, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEAD_BEEF, 4'd3};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        5'd2,  32'h80FF_1234, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_FF80, 4'd5};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        5'd3,  32'h80FF_1234, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_0080, 4'd6};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0,  32'h0,        0, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0,        4'd0};
    vecs[4]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        5'd4,  32'h1234_5678, 2, 32'h0000_0100, 4'b1111, 32'h0,        32'h1234_5678, 4'd3};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        5'd5,  32'h8001_7FFF, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_8001, 4'd7};
    vecs[6]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        5'd6,  32'h8001_F00D, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_F00D, 4'd8};
    vecs[7]  = '{1'b1, 3'b000, 32'h0000_0201, 32'h1234_56A5, 5'd0,  32'h0,        1, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0,        4'd0};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 5'd0,  32'h0,        0, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D, 32'h0,        4'd0};
    vecs[9]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,        5'd7,  32'h0000_007F, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_007F, 4'd5};
    vecs[10] = '{1'b0, 3'b011, 32'h0000_0108, 32'h0,        5'd8,  32'h55AA_55AA, 1, 32'h0000_0108, 4'b1111, 32'h0,        32'h55AA_55AA, 4'd3};
    vecs[11] = '{1'b1, 3'b111, 32'h0000_010C, 32'h0102_0304, 5'd0,  32'h0,        0, 32'h0000_010C, 4'b1111, 32'h0102_0304, 32'h0,        4'd0};
    vecs[12] = '{1'b0, 3'b101, 32'h0000_0103, 32'h0,        5'd9,  32'hABCD_1234, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0000_ABCD, 4'd8};
    vecs[13] = '{1'b1, 3'b001, 32'h0000_0101, 32'h0000_BEEF, 5'd0,  32'h0,        0, 32'h0000_0100, 4'b0011, 32'hBEEF_BEEF, 32'h0,        4'd0};

    rst = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    dmem_rdata = 32'h0; dmem_resp = 1'b0;

    #2;
    check("rst_read", 32'(dmem_read), 32'd0);
    check("rst_write", 32'(dmem_write), 32'd0);
    check("rst_addr", dmem_address, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_be", 32'(dmem_byte_enable), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_sel", 32'(wb_sel), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      mem[vecs[i].addr[31:2]] = vecs[i].rdata;
      do_access(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].lat,
                vecs[i].e_addr, vecs[i].e_be, vecs[i].e_wdata, vecs[i].e_wb, vecs[i].e_sel);
    end

    // Back-to-back store then load to the same word: the load sees the stored byte.
    mem[30'h80] = 32'h1122_3344;
    do_access(1'b1, 3'b000, 32'h0000_0200, 32'h0000_005A, 5'd0, 0,
              32'h0000_0200, 4'b0001, 32'h5A5A_5A5A, 32'h0, 4'd0);
    do_access(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd10, 0,
              32'h0000_0200, 4'b1111, 32'h0, 32'h1122_335A, 4'd3);
    @(posedge clk); @(negedge clk);
    check("b2b_wb_pulse_end", 32'(wb_valid), 32'd0);

    // Reset while a load is outstanding, then a stray resp after release.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0040; req_rd = 5'd11;
    @(posedge clk); @(negedge clk);
    check("mid_busy_read", 32'(dmem_read), 32'd1);
    #2 rst = 1'b0; req_valid = 1'b0;
    #1;
    check("mid_rst_read", 32'(dmem_read), 32'd0);
    check("mid_rst_addr", dmem_address, 32'h0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    #1;
    check("late_resp_stall", 32'(stall), 32'd0);
    @(posedge clk); @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check("late_resp_no_wb", 32'(wb_valid), 32'd0);
    check("late_resp_no_req", 32'({dmem_read, dmem_write}), 32'd0);
    mem[30'h10] = 32'h0BAD_CAFE;
    do_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd12, 1,
              32'h0000_0040, 4'b1111, 32'h0, 32'h0BAD_CAFE, 4'd3);

    // Randomized accesses over a small window so loads hit earlier stores.
    for (int n = 0; n < 40; n++) begin
      r_st   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = 32'h0000_0300 + 32'($urandom_range(0, 15));
      if (!mem.exists(r_addr[31:2])) mem[r_addr[31:2]] = $urandom;
      m_wdata = $urandom;
      model(r_st, r_f3, r_addr, m_wdata, mem[r_addr[31:2]], m_be, m_wdata, m_wb, m_sel);
      do_access(r_st, r_f3, r_addr, m_wdata, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                {r_addr[31:2], 2'b00}, m_be, m_wdata, m_wb, m_sel);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
